// File: rtl/hdlc_rx_frame_ring.sv
// HDLC receive buffer holding up to NUM_FRAMES good frames in a slot ring.
// Bad, aborted or ring-full frames are dropped without host involvement.
module hdlc_rx_frame_ring #(
    parameter int unsigned NUM_FRAMES = 4,
    parameter int unsigned MAX_BYTES  = 128,
    parameter int unsigned FCS_EN     = 1
) (
    input  logic                                Clk,
    input  logic                                Rst,
    input  logic                                Rx_ValidFrame,
    input  logic                                Rx_NewByte,
    input  logic [7:0]                          Rx_Data,
    input  logic                                Rx_EoF,
    input  logic                                Rx_AbortSignal,
    input  logic                                Rx_FrameError,
    input  logic                                Rx_FCSerr,
    input  logic                                Rx_RdBuff,
    input  logic                                Rx_Drop,
    output logic                                Rx_Ready,
    output logic [7:0]                          Rx_DataBuffOut,
    output logic [$clog2(MAX_BYTES+1)-1:0]      Rx_FrameSize,
    output logic                                Rx_Overflow,
    output logic [$clog2(NUM_FRAMES+1)-1:0]     Rx_FramesPending,
    output logic [7:0]                          Rx_LostCnt
);
    localparam int unsigned SIZE_W  = $clog2(MAX_BYTES + 1);
    localparam int unsigned CNT_W   = $clog2(NUM_FRAMES + 1);
    localparam int unsigned PTR_W   = $clog2(NUM_FRAMES);
    localparam int unsigned IDX_W   = $clog2(MAX_BYTES);
    localparam int unsigned FCS_LEN = (FCS_EN != 0) ? 2 : 0;

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} wrState_t;

    wrState_t          wrState;
    logic [PTR_W-1:0]  wrPtr, rdPtr, rdPtrNext;
    logic [SIZE_W-1:0] wrIdx, rdIdx, idxAfter, commitSize, headSize, headSizeNext;
    logic              wrOvf, wrBad, ovfAfter, badAfter, headOvfNext;
    logic              byteFits, byteWr, tooShort, commit;
    logic              notEmpty, doDrop, doRead, lastByte, doRelease;
    logic [CNT_W-1:0]  count, countNext;

    logic [7:0]        mem      [NUM_FRAMES][MAX_BYTES];
    logic [SIZE_W-1:0] slotSize [NUM_FRAMES];
    logic              slotOvf  [NUM_FRAMES];

    // Write-side decode: the byte of this cycle is counted before EoF is judged
    always_comb begin
        byteFits   = wrIdx < SIZE_W'(MAX_BYTES);
        byteWr     = (wrState == COLLECT) && Rx_NewByte && byteFits;
        idxAfter   = wrIdx + SIZE_W'(byteWr);
        ovfAfter   = wrOvf | ((wrState == COLLECT) && Rx_NewByte && !byteFits);
        badAfter   = wrBad | Rx_AbortSignal | Rx_FrameError | ((FCS_EN != 0) && Rx_FCSerr);
        tooShort   = idxAfter <= SIZE_W'(FCS_LEN);
        commitSize = idxAfter - SIZE_W'(FCS_LEN);
        commit     = (wrState == COLLECT) && Rx_EoF && !badAfter && !tooShort;
    end

    // Read-side decode: Drop wins over RdBuff, last byte of head auto-releases
    always_comb begin
        notEmpty  = count != '0;
        headSize  = slotSize[rdPtr];
        doDrop    = notEmpty && Rx_Drop;
        doRead    = notEmpty && Rx_RdBuff && !Rx_Drop;
        lastByte  = rdIdx == (headSize - SIZE_W'(1));
        doRelease = doDrop || (doRead && lastByte);
        rdPtrNext = doRelease ? rdPtr + PTR_W'(1) : rdPtr;
        case ({commit, doRelease})
            2'b10:   countNext = count + CNT_W'(1);
            2'b01:   countNext = count - CNT_W'(1);
            default: countNext = count;
        endcase
        // a frame committed into an emptied ring becomes the head straight away
        if (commit && (rdPtrNext == wrPtr)) begin
            headSizeNext = commitSize;
            headOvfNext  = ovfAfter;
        end else begin
            headSizeNext = slotSize[rdPtrNext];
            headOvfNext  = slotOvf[rdPtrNext];
        end
    end

    // Write FSM
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wrState    <= IDLE;
            wrPtr      <= '0;
            wrIdx      <= '0;
            wrOvf      <= 1'b0;
            wrBad      <= 1'b0;
            Rx_LostCnt <= '0;
            for (int unsigned i = 0; i < NUM_FRAMES; i++) begin
                slotSize[i] <= '0;
                slotOvf[i]  <= 1'b0;
            end
        end else begin
            case (wrState)
                IDLE: begin
                    if (Rx_ValidFrame) begin
                        if (count != CNT_W'(NUM_FRAMES)) begin
                            wrState <= COLLECT;
                            wrIdx   <= '0;
                            wrOvf   <= 1'b0;
                            wrBad   <= 1'b0;
                        end else begin
                            wrState <= DISCARD;
                            if (Rx_LostCnt != 8'hFF) Rx_LostCnt <= Rx_LostCnt + 8'd1;
                        end
                    end
                end
                COLLECT: begin
                    wrIdx <= idxAfter;
                    wrOvf <= ovfAfter;
                    wrBad <= badAfter;
                    if (Rx_EoF) begin
                        wrState <= IDLE;
                        if (commit) begin
                            slotSize[wrPtr] <= commitSize;
                            slotOvf[wrPtr]  <= ovfAfter;
                            wrPtr           <= wrPtr + PTR_W'(1);
                        end
                    end else if (!Rx_ValidFrame) begin
                        wrState <= IDLE;
                    end
                end
                DISCARD: begin
                    if (Rx_EoF || !Rx_ValidFrame) wrState <= IDLE;
                end
                default: wrState <= IDLE;
            endcase
        end
    end

    // Slot byte storage
    always_ff @(posedge Clk) begin
        if (byteWr) mem[wrPtr][IDX_W'(wrIdx)] <= Rx_Data;
    end

    // Read side and head-of-ring status
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rdPtr          <= '0;
            rdIdx          <= '0;
            count          <= '0;
            Rx_Ready       <= 1'b0;
            Rx_DataBuffOut <= '0;
            Rx_FrameSize   <= '0;
            Rx_Overflow    <= 1'b0;
        end else begin
            if (doRead) Rx_DataBuffOut <= mem[rdPtr][IDX_W'(rdIdx)];
            if (doRelease)   rdIdx <= '0;
            else if (doRead) rdIdx <= rdIdx + SIZE_W'(1);
            rdPtr        <= rdPtrNext;
            count        <= countNext;
            Rx_Ready     <= countNext != '0;
            Rx_FrameSize <= (countNext != '0) ? headSizeNext : '0;
            Rx_Overflow  <= (countNext != '0) ? headOvfNext : 1'b0;
        end
    end

    assign Rx_FramesPending = count;

endmodule

// File: tb/tb_hdlc_rx_frame_ring.sv
// Directed bench for hdlc_rx_frame_ring with default parameters (4 slots, 128 bytes, FCS on).
module tb_hdlc_rx_frame_ring;
    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Rx_ValidFrame = 1'b0, Rx_NewByte = 1'b0, Rx_EoF = 1'b0;
    logic [7:0] Rx_Data = '0;
    logic       Rx_AbortSignal = 1'b0, Rx_FrameError = 1'b0, Rx_FCSerr = 1'b0;
    logic       Rx_RdBuff = 1'b0, Rx_Drop = 1'b0;
    logic       Rx_Ready, Rx_Overflow;
    logic [7:0] Rx_DataBuffOut, Rx_LostCnt;
    logic [7:0] Rx_FrameSize;
    logic [2:0] Rx_FramesPending;

    int nChecks = 0;
    int nFail   = 0;

    hdlc_rx_frame_ring dut (
        .Clk(Clk), .Rst(Rst),
        .Rx_ValidFrame(Rx_ValidFrame), .Rx_NewByte(Rx_NewByte), .Rx_Data(Rx_Data),
        .Rx_EoF(Rx_EoF), .Rx_AbortSignal(Rx_AbortSignal), .Rx_FrameError(Rx_FrameError),
        .Rx_FCSerr(Rx_FCSerr), .Rx_RdBuff(Rx_RdBuff), .Rx_Drop(Rx_Drop),
        .Rx_Ready(Rx_Ready), .Rx_DataBuffOut(Rx_DataBuffOut), .Rx_FrameSize(Rx_FrameSize),
        .Rx_Overflow(Rx_Overflow), .Rx_FramesPending(Rx_FramesPending), .Rx_LostCnt(Rx_LostCnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs change and outputs are sampled on the falling edge
    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic startFrame();
        Rx_ValidFrame = 1'b1;
        cyc();
    endtask

    task automatic sendByte(input logic [7:0] b);
        Rx_NewByte = 1'b1;
        Rx_Data    = b;
        cyc();
        Rx_NewByte = 1'b0;
    endtask

    task automatic endFrame(input logic fcsErr);
        Rx_EoF        = 1'b1;
        Rx_FCSerr     = fcsErr;
        Rx_ValidFrame = 1'b0;
        cyc();
        Rx_EoF         = 1'b0;
        Rx_FCSerr      = 1'b0;
        Rx_AbortSignal = 1'b0;
        Rx_FrameError  = 1'b0;
    endtask

    task automatic sendFrame(input int n, input logic [7:0] base, input logic fcsErr);
        startFrame();
        for (int i = 0; i < n; i++) sendByte(base + 8'(i));
        endFrame(fcsErr);
    endtask

    task automatic readByte(input string tag, input logic [7:0] exp);
        Rx_RdBuff = 1'b1;
        cyc();
        Rx_RdBuff = 1'b0;
        chk(tag, 32'(Rx_DataBuffOut), 32'(exp));
    endtask

    task automatic chkStatus(input string tag, input logic rdy, input int pend, input int size, input logic ovf);
        chk({tag, ".ready"}, 32'(Rx_Ready), 32'(rdy));
        chk({tag, ".pending"}, 32'(Rx_FramesPending), 32'(pend));
        chk({tag, ".size"}, 32'(Rx_FrameSize), 32'(size));
        chk({tag, ".ovf"}, 32'(Rx_Overflow), 32'(ovf));
    endtask

    task automatic chkAllZero(input string tag);
        chkStatus(tag, 1'b0, 0, 0, 1'b0);
        chk({tag, ".data"}, 32'(Rx_DataBuffOut), 32'h0);
        chk({tag, ".lost"}, 32'(Rx_LostCnt), 32'h0);
    endtask

    initial begin
        // reset state
        cyc(); cyc();
        chkAllZero("reset");
        Rst = 1'b1;
        cyc();

        // single good frame: 6 bytes incl. FCS -> 4 payload bytes
        sendFrame(6, 8'h11 - 8'h11 + 8'h11, 1'b0);
        chkStatus("single", 1'b1, 1, 4, 1'b0);
        readByte("single.rd0", 8'h11);
        readByte("single.rd1", 8'h12);
        readByte("single.rd2", 8'h13);
        readByte("single.rd3", 8'h14);
        chkStatus("single.done", 1'b0, 0, 0, 1'b0);

        // discard paths
        startFrame();
        sendByte(8'h01);
        Rx_AbortSignal = 1'b1;
        sendByte(8'h02);
        Rx_AbortSignal = 1'b0;
        sendByte(8'h03);
        endFrame(1'b0);
        chkStatus("abort", 1'b0, 0, 0, 1'b0);

        startFrame();
        sendByte(8'h01);
        sendByte(8'h02);
        sendByte(8'h03);
        Rx_FrameError = 1'b1;
        endFrame(1'b0);
        chkStatus("ferr", 1'b0, 0, 0, 1'b0);

        sendFrame(5, 8'h40, 1'b1);
        chkStatus("fcserr", 1'b0, 0, 0, 1'b0);

        startFrame();
        sendByte(8'h01);
        sendByte(8'h02);
        sendByte(8'h03);
        Rx_ValidFrame = 1'b0;
        cyc();
        cyc();
        chkStatus("vfall", 1'b0, 0, 0, 1'b0);

        sendFrame(2, 8'h50, 1'b0);
        chkStatus("empty", 1'b0, 0, 0, 1'b0);

        // ring full: 4 frames of payload 1..4, 5th frame lost
        for (int k = 0; k < 4; k++) sendFrame(k + 3, 8'hA0 + 8'(k * 16), 1'b0);
        chkStatus("full", 1'b1, 4, 1, 1'b0);
        sendFrame(6, 8'hE0, 1'b0);
        chkStatus("full.5th", 1'b1, 4, 1, 1'b0);
        chk("full.lost", 32'(Rx_LostCnt), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("ring.size", 32'(Rx_FrameSize), 32'(k + 1));
            for (int j = 0; j <= k; j++) readByte("ring.rd", 8'hA0 + 8'(k * 16 + j));
            chk("ring.pending", 32'(Rx_FramesPending), 32'(3 - k));
        end
        chk("ring.ready", 32'(Rx_Ready), 32'h0);

        // overflow: 140 bytes -> 128 stored, 126 payload
        sendFrame(140, 8'h00, 1'b0);
        chkStatus("ovf", 1'b1, 1, 126, 1'b1);
        sendFrame(4, 8'h51, 1'b0);
        chkStatus("ovf.next", 1'b1, 2, 126, 1'b1);

        // drop and read together: drop wins, data holds last read byte (frame 3, byte 3)
        Rx_Drop   = 1'b1;
        Rx_RdBuff = 1'b1;
        cyc();
        Rx_Drop   = 1'b0;
        Rx_RdBuff = 1'b0;
        chk("droprd.data", 32'(Rx_DataBuffOut), 32'hD3);
        chkStatus("droprd", 1'b1, 1, 2, 1'b0);
        readByte("after.rd0", 8'h51);
        readByte("after.rd1", 8'h52);
        chk("after.ready", 32'(Rx_Ready), 32'h0);

        // drop of head in the same cycle as the next frame commits
        sendFrame(4, 8'h01, 1'b0);
        chkStatus("dc.pre", 1'b1, 1, 2, 1'b0);
        startFrame();
        for (int i = 0; i < 5; i++) sendByte(8'h21 + 8'(i));
        Rx_Drop = 1'b1;
        endFrame(1'b0);
        Rx_Drop = 1'b0;
        chkStatus("dc", 1'b1, 1, 3, 1'b0);
        readByte("dc.rd0", 8'h21);
        readByte("dc.rd1", 8'h22);
        readByte("dc.rd2", 8'h23);
        chk("dc.ready", 32'(Rx_Ready), 32'h0);

        // async reset mid-read and mid-frame
        sendFrame(6, 8'h31, 1'b0);
        readByte("rst.rd0", 8'h31);
        startFrame();
        sendByte(8'hEE);
        Rx_NewByte = 1'b1;
        Rx_Data    = 8'hEF;
        #2;
        Rst = 1'b0;
        #1;
        chkAllZero("asyncrst");
        Rx_NewByte    = 1'b0;
        Rx_ValidFrame = 1'b0;
        cyc();
        Rst = 1'b1;
        cyc();
        sendFrame(5, 8'h71, 1'b0);
        chkStatus("postrst", 1'b1, 1, 3, 1'b0);
        readByte("postrst.rd0", 8'h71);
        readByte("postrst.rd1", 8'h72);
        readByte("postrst.rd2", 8'h73);
        chk("postrst.ready", 32'(Rx_Ready), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
